// File: rtl/compression_output_scheduler.sv
// compression_output_scheduler: ping-pong buffers parallel I/Q compression vectors
// and streams each one as Lanes-wide beats under a valid/ready handshake.
module compression_output_scheduler #(
    parameter int Data_width        = 10,
    parameter int No_channels       = 128,
    parameter int Lanes             = 8,
    parameter int Samples_per_frame = 416,
    localparam int Beats = No_channels / Lanes,
    localparam int Bw    = $clog2(Beats),
    localparam int Sw    = $clog2(Samples_per_frame)
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic [Data_width*No_channels-1:0] I_data_i,
    input  logic [Data_width*No_channels-1:0] Q_data_i,
    input  logic                              data_valid_i,
    input  logic                              frame_start_i,
    input  logic                              overflow_clr_i,
    output logic [2*Data_width*Lanes-1:0]     out_data_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [Bw-1:0]                     out_beat_o,
    output logic                              out_last_beat_o,
    output logic                              out_last_sample_o,
    output logic                              overflow_o,
    output logic                              busy_o
);
    typedef enum logic {IDLE, STREAM} state_t;
    localparam int VW = Data_width * No_channels;
    localparam logic [Bw-1:0] BMAX = Bw'(Beats - 1);
    localparam logic [Sw-1:0] SMAX = Sw'(Samples_per_frame - 1);

    state_t state, state_n;
    logic [VW-1:0] mem_i [2];
    logic [VW-1:0] mem_q [2];
    logic [VW-1:0] src_i, src_q;
    logic [1:0] full, full_f, full_n;
    logic wr_ptr, rd_ptr, wr_n, rd_n, cap_ptr;
    logic fire, done, capture, drop;
    logic [Bw-1:0] beat_n;
    logic [Sw-1:0] sample, sample_n;
    logic [2*Data_width*Lanes-1:0] data_n;

    // Freeing the read buffer is resolved before the capture decision, so a
    // vector arriving on the final handshake always finds room.
    always_comb begin
        fire     = state == STREAM && out_ready_i;
        done     = fire && out_beat_o == BMAX;
        full_f   = frame_start_i ? 2'b00 : full & ~({1'b0, done} << rd_ptr);
        rd_n     = frame_start_i ? 1'b0 : rd_ptr ^ done;
        cap_ptr  = frame_start_i ? 1'b0 : wr_ptr;
        sample_n = frame_start_i ? '0 : !done ? sample : sample == SMAX ? '0 : sample + 1'b1;
        beat_n   = frame_start_i || done ? '0 : fire ? out_beat_o + 1'b1 : out_beat_o;
        capture  = data_valid_i && !full_f[cap_ptr];
        drop     = data_valid_i && full_f[cap_ptr];
        full_n   = full_f | ({1'b0, capture} << cap_ptr);
        wr_n     = cap_ptr ^ capture;
        state_n  = full_n[rd_n] ? STREAM : IDLE;
        src_i    = capture && cap_ptr == rd_n ? I_data_i : mem_i[rd_n];
        src_q    = capture && cap_ptr == rd_n ? Q_data_i : mem_q[rd_n];
        data_n   = '0;
        for (int l = 0; l < Lanes; l++) begin
            data_n[2*Data_width*l +: Data_width] =
                src_i[(int'(beat_n)*Lanes + l)*Data_width +: Data_width];
            data_n[2*Data_width*l + Data_width +: Data_width] =
                src_q[(int'(beat_n)*Lanes + l)*Data_width +: Data_width];
        end
    end

    always_ff @(posedge clk_i) begin
        if (capture) begin
            mem_i[cap_ptr] <= I_data_i;
            mem_q[cap_ptr] <= Q_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state             <= IDLE;
            full              <= '0;
            wr_ptr            <= 1'b0;
            rd_ptr            <= 1'b0;
            sample            <= '0;
            out_valid_o       <= 1'b0;
            out_beat_o        <= '0;
            out_last_beat_o   <= 1'b0;
            out_last_sample_o <= 1'b0;
            overflow_o        <= 1'b0;
            busy_o            <= 1'b0;
            out_data_o        <= '0;
        end else begin
            state             <= state_n;
            full              <= full_n;
            wr_ptr            <= wr_n;
            rd_ptr            <= rd_n;
            sample            <= sample_n;
            out_valid_o       <= state_n == STREAM;
            out_beat_o        <= beat_n;
            out_last_beat_o   <= full_n[rd_n] && beat_n == BMAX;
            out_last_sample_o <= full_n[rd_n] && sample_n == SMAX;
            overflow_o        <= drop || (overflow_o && !overflow_clr_i);
            busy_o            <= |full_n;
            out_data_o        <= data_n;
        end
    end
endmodule

// File: tb/tb_compression_output_scheduler.sv
// tb_compression_output_scheduler: random and directed traffic checked every cycle
// against a two-deep vector queue model of the scheduler.
module tb_compression_output_scheduler;
    localparam int DW = 10, NC = 128, L = 8, SPF = 416, B = NC / L;
    localparam int VW = DW * NC, OW = 2 * DW * L;

    typedef struct {
        logic [VW-1:0] i;
        logic [VW-1:0] q;
    } vec_t;

    logic clk_i = 1'b0, reset_ni = 1'b1;
    logic [VW-1:0] I_data_i = '0, Q_data_i = '0;
    logic data_valid_i = 1'b0, frame_start_i = 1'b0, overflow_clr_i = 1'b0, out_ready_i = 1'b0;
    logic [OW-1:0] out_data_o;
    logic [3:0] out_beat_o;
    logic out_valid_o, out_last_beat_o, out_last_sample_o, overflow_o, busy_o;

    vec_t mq[$];
    int m_beat = 0, m_cnt = 0, m_xfers = 0;
    logic m_ov = 1'b0;
    int n_checks = 0, n_fail = 0;
    int dut_xfers = 0, dut_vecs = 0, ls_count = 0, ls_at = -1;

    compression_output_scheduler #(
        .Data_width(DW), .No_channels(NC), .Lanes(L), .Samples_per_frame(SPF)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .I_data_i(I_data_i), .Q_data_i(Q_data_i),
        .data_valid_i(data_valid_i), .frame_start_i(frame_start_i),
        .overflow_clr_i(overflow_clr_i), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_beat_o(out_beat_o), .out_last_beat_o(out_last_beat_o),
        .out_last_sample_o(out_last_sample_o), .overflow_o(overflow_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] exp_data();
        logic [OW-1:0] d;
        d = '0;
        for (int l = 0; l < L; l++) begin
            d[2*DW*l +: DW]      = mq[0].i[(m_beat*L + l)*DW +: DW];
            d[2*DW*l + DW +: DW] = mq[0].q[(m_beat*L + l)*DW +: DW];
        end
        return d;
    endfunction

    function automatic logic [VW-1:0] rvec();
        logic [VW-1:0] v;
        for (int c = 0; c < NC; c++) v[c*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // Model: a queue of at most two vectors; the head streams beat by beat and
    // its frame sample number is the count of vectors completed since frame start.
    task automatic model_step();
        logic fire;
        fire = mq.size() > 0 && out_ready_i;
        if (fire) m_xfers++;
        if (frame_start_i) begin
            mq.delete();
            m_beat = 0;
            m_cnt  = 0;
        end else if (fire) begin
            if (m_beat == B - 1) begin
                mq.delete(0);
                m_beat = 0;
                m_cnt  = (m_cnt + 1) % SPF;
            end else m_beat++;
        end
        if (data_valid_i && mq.size() < 2) begin
            mq.push_back('{i: I_data_i, q: Q_data_i});
            m_ov = overflow_clr_i ? 1'b0 : m_ov;
        end else if (data_valid_i) m_ov = 1'b1;
        else m_ov = overflow_clr_i ? 1'b0 : m_ov;
    endtask

    always @(negedge reset_ni) begin
        mq.delete();
        m_beat = 0;
        m_cnt  = 0;
        m_ov   = 1'b0;
    end

    always @(posedge clk_i) begin
        if (out_valid_o && out_ready_i) begin
            dut_xfers++;
            if (out_last_beat_o) begin
                if (out_last_sample_o) begin
                    ls_count++;
                    ls_at = dut_vecs;
                end
                dut_vecs++;
            end
        end
        if (reset_ni) model_step();
        #1;
        chk("valid", OW'(out_valid_o), OW'(mq.size() > 0));
        chk("busy", OW'(busy_o), OW'(mq.size() > 0));
        chk("overflow", OW'(overflow_o), OW'(m_ov));
        chk("beat", OW'(out_beat_o), OW'(m_beat));
        chk("last_beat", OW'(out_last_beat_o), OW'(mq.size() > 0 && m_beat == B - 1));
        chk("last_sample", OW'(out_last_sample_o), OW'(mq.size() > 0 && m_cnt == SPF - 1));
        if (mq.size() > 0) chk("data", out_data_o, exp_data());
    end

    task automatic send(input logic [VW-1:0] i, input logic [VW-1:0] q);
        I_data_i     = i;
        Q_data_i     = q;
        data_valid_i = 1'b1;
        @(negedge clk_i);
        data_valid_i = 1'b0;
    endtask

    task automatic wait_beat(input int b);
        int k;
        k = 0;
        while (!(out_valid_o && out_beat_o == 4'(b)) && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        chk("wait_beat", OW'({out_valid_o, out_beat_o}), OW'({1'b1, 4'(b)}));
    endtask

    initial begin
        logic [VW-1:0] vi, vq;
        int x0, v0, ls0;
        #1 reset_ni = 1'b0;
        #1;
        chk("rst_valid", OW'(out_valid_o), OW'(0));
        chk("rst_flags", OW'({out_beat_o, out_last_beat_o, out_last_sample_o, overflow_o, busy_o}), OW'(0));
        chk("rst_data", out_data_o, OW'(0));
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);

        // single vector, I=c, Q=1023-c, ready held high
        for (int c = 0; c < NC; c++) begin
            vi[c*DW +: DW] = DW'(c);
            vq[c*DW +: DW] = DW'(1023 - c);
        end
        out_ready_i = 1'b1;
        x0 = dut_xfers;
        v0 = dut_vecs;
        I_data_i = vi;
        Q_data_i = vq;
        data_valid_i = 1'b1;
        @(posedge clk_i);
        #2;
        chk("first_beat", OW'({out_valid_o, out_beat_o}), OW'({1'b1, 4'd0}));
        @(negedge clk_i);
        data_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        chk("b3_beat", OW'(out_beat_o), OW'(3));
        chk("b3_l2_i", OW'(out_data_o[40 +: 10]), OW'(26));
        chk("b3_l2_q", OW'(out_data_o[50 +: 10]), OW'(997));
        repeat (20) @(negedge clk_i);
        chk("single_beats", OW'(dut_xfers - x0), OW'(16));
        chk("single_vecs", OW'(dut_vecs - v0), OW'(1));

        // three back-to-back vectors with ready low: third one is dropped
        out_ready_i = 1'b0;
        x0 = dut_xfers;
        send(rvec(), rvec());
        send(rvec(), rvec());
        send(rvec(), rvec());
        chk("ovf_set", OW'(overflow_o), OW'(1));
        chk("ovf_busy", OW'(busy_o), OW'(1));
        out_ready_i = 1'b1;
        repeat (40) @(negedge clk_i);
        chk("ovf_beats", OW'(dut_xfers - x0), OW'(32));
        chk("ovf_sticky", OW'(overflow_o), OW'(1));
        overflow_clr_i = 1'b1;
        @(negedge clk_i);
        overflow_clr_i = 1'b0;
        chk("ovf_clr", OW'(overflow_o), OW'(0));

        // random traffic with backpressure
        for (int k = 0; k < 1500; k++) begin
            out_ready_i    = $urandom_range(0, 9) < 7;
            data_valid_i   = $urandom_range(0, 13) == 0;
            overflow_clr_i = $urandom_range(0, 40) == 0;
            frame_start_i  = $urandom_range(0, 300) == 0;
            if (data_valid_i) begin
                I_data_i = rvec();
                Q_data_i = rvec();
            end
            @(negedge clk_i);
        end
        data_valid_i   = 1'b0;
        overflow_clr_i = 1'b0;
        frame_start_i  = 1'b0;
        out_ready_i    = 1'b1;
        repeat (40) @(negedge clk_i);
        chk("xfer_total", OW'(dut_xfers), OW'(m_xfers));

        // a full frame plus one, with free and capture on the same edge
        frame_start_i = 1'b1;
        @(negedge clk_i);
        frame_start_i = 1'b0;
        v0  = dut_vecs;
        ls0 = ls_count;
        for (int k = 0; k < SPF + 1; k++) begin
            send(rvec(), rvec());
            repeat (15) @(negedge clk_i);
        end
        repeat (20) @(negedge clk_i);
        chk("frame_vecs", OW'(dut_vecs - v0), OW'(SPF + 1));
        chk("ls_count", OW'(ls_count - ls0), OW'(1));
        chk("ls_at", OW'(ls_at - v0), OW'(SPF - 1));

        // abort at beat 7 of the second buffered vector
        send(rvec(), rvec());
        send(rvec(), rvec());
        wait_beat(15);
        @(negedge clk_i);
        wait_beat(7);
        frame_start_i = 1'b1;
        @(posedge clk_i);
        #2;
        chk("abort_valid", OW'(out_valid_o), OW'(0));
        chk("abort_busy", OW'(busy_o), OW'(0));
        @(negedge clk_i);
        frame_start_i = 1'b0;
        send(rvec(), rvec());
        send(rvec(), rvec());
        wait_beat(15);
        @(negedge clk_i);
        wait_beat(7);
        vi = rvec();
        frame_start_i = 1'b1;
        I_data_i = vi;
        Q_data_i = rvec();
        data_valid_i = 1'b1;
        @(posedge clk_i);
        #2;
        chk("restart_beat", OW'({out_valid_o, out_beat_o, busy_o}), OW'({1'b1, 4'd0, 1'b1}));
        chk("restart_l0", OW'(out_data_o[0 +: 10]), OW'(vi[0 +: 10]));
        @(negedge clk_i);
        frame_start_i = 1'b0;
        data_valid_i  = 1'b0;
        repeat (20) @(negedge clk_i);

        // asynchronous reset in the middle of a beat, with overflow pending
        out_ready_i = 1'b0;
        send(rvec(), rvec());
        send(rvec(), rvec());
        send(rvec(), rvec());
        out_ready_i = 1'b1;
        wait_beat(5);
        #2 reset_ni = 1'b0;
        #1;
        chk("arst_valid", OW'({out_valid_o, out_beat_o, out_last_beat_o}), OW'(0));
        chk("arst_flags", OW'({out_last_sample_o, overflow_o, busy_o}), OW'(0));
        chk("arst_data", out_data_o, OW'(0));
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        x0 = dut_xfers;
        send(rvec(), rvec());
        chk("post_rst", OW'({out_valid_o, out_beat_o, out_last_sample_o}), OW'({1'b1, 4'd0, 1'b0}));
        repeat (20) @(negedge clk_i);
        chk("post_rst_beats", OW'(dut_xfers - x0), OW'(16));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/compression_output_scheduler.md
COMPRESSION_OUTPUT_SCHEDULER -- requirements
Module: compression_output_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- Data_width, 10, bits per I or Q sample.
- No_channels, 128, channels in the parallel compression output.
- Lanes, 8, channels carried per output beat; No_channels SHALL be an integer multiple of Lanes.
- Samples_per_frame, 416, decimated samples per channel per frame (Samples_per_channel / Decimation_factor).
REQ-002 Derived: Beats = No_channels/Lanes (16 at defaults); Bw = $clog2(Beats); Sw = $clog2(Samples_per_frame).
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, single clock.
- reset_ni, in, 1, asynchronous active-low reset.
- I_data_i, in, Data_width*No_channels, I vector; channel c at [Data_width*c +: Data_width].
- Q_data_i, in, Data_width*No_channels, Q vector, same packing.
- data_valid_i, in, 1, one-cycle strobe: I/Q vectors valid.
- frame_start_i, in, 1, one-cycle strobe: abort and restart the frame.
- overflow_clr_i, in, 1, clears overflow_o.
- out_data_o, out, 2*Data_width*Lanes, beat payload.
- out_valid_o, out, 1, beat valid.
- out_ready_i, in, 1, downstream accepts the beat.
- out_beat_o, out, Bw, index of the current beat.
- out_last_beat_o, out, 1, current beat is Beats-1.
- out_last_sample_o, out, 1, current vector is frame sample Samples_per_frame-1.
- overflow_o, out, 1, sticky: an input vector was dropped.
- busy_o, out, 1, either buffer occupied.

Function
REQ-004 Two vector buffers (ping-pong) SHALL be used, each holding I+Q of all channels and a full flag; writes go to the write pointer, reads come from the read pointer.
REQ-005 On data_valid_i with a free buffer, the vectors SHALL be captured into the write-pointer buffer, which is then marked full, and the write pointer SHALL toggle.
REQ-006 On data_valid_i with both buffers full, the vector SHALL be dropped, overflow_o SHALL be set from the next cycle, and buffer contents SHALL be unchanged.
REQ-007 FSM states: IDLE (no full buffer) and STREAM (read buffer full); IDLE->STREAM when the read buffer becomes full; STREAM->IDLE after the last-beat handshake if the other buffer is empty.
REQ-008 Capture latency: a data_valid_i in cycle t into empty buffers SHALL give out_valid_o=1, out_beat_o=0 in cycle t+1.
REQ-009 Beat b payload: lane l (0..Lanes-1) carries channel c=b*Lanes+l, with I at [2*Data_width*l +: Data_width] and Q at [2*Data_width*l+Data_width +: Data_width].
REQ-010 Handshake: a beat transfers when out_valid_o && out_ready_i; while out_valid_o=1 and out_ready_i=0, out_data_o, out_beat_o and the flags SHALL hold stable.
REQ-011 On a transfer of beat b<Beats-1, the next cycle SHALL present beat b+1.
REQ-012 On a transfer of beat Beats-1, the read buffer SHALL be freed, the read pointer SHALL toggle, and the sample counter SHALL increment, wrapping from Samples_per_frame-1 to 0.
REQ-013 If the other buffer is full at that point, beat 0 of that buffer SHALL be presented in the next cycle with no bubble.
REQ-014 Simultaneous free (REQ-012) and capture (REQ-005) in one cycle SHALL both take effect; freeing is evaluated first, so a capture is never dropped in this case.
REQ-015 out_last_sample_o SHALL be 1 on all beats of the vector whose sample count is Samples_per_frame-1.
REQ-016 frame_start_i SHALL, in the next cycle: clear both full flags and both pointers, clear beat index and sample counter, and return to IDLE (out_valid_o=0). This abort is the only permitted withdrawal of out_valid_o.
REQ-017 frame_start_i together with data_valid_i SHALL flush first, then capture the vector into buffer 0 as sample 0.
REQ-018 overflow_clr_i SHALL clear overflow_o next cycle; if it coincides with a new drop, the set SHALL win.
REQ-019 busy_o = OR of the full flags; all outputs SHALL be registered.

Reset
REQ-020 On reset_ni=0, asynchronously: out_valid_o=0, out_beat_o=0, out_last_beat_o=0, out_last_sample_o=0, overflow_o=0, busy_o=0, out_data_o=0, full flags and pointers=0, sample counter=0, FSM=IDLE. Buffer data need not be reset.
REQ-021 Reset asserted mid-stream SHALL abort immediately, with no beat completing afterwards; the first data_valid_i after release SHALL be sample 0.

Verification
REQ-022 Single vector, channel c with I=c, Q=1023-c, out_ready_i=1 -> 16 consecutive beats starting at t+1; beat 3 lane 2 gives I=26, Q=997; out_last_beat_o=1 only on beat 15.
REQ-023 Three data_valid_i pulses 1 cycle apart, out_ready_i=0 -> the third vector is dropped and overflow_o=1; after releasing ready, exactly 32 beats; overflow_clr_i then gives overflow_o=0.
REQ-024 Random out_ready_i backpressure -> payload stable while stalled, no beat lost or duplicated; scoreboard matches all channels.
REQ-025 416 vectors -> out_last_sample_o is set only on the 416th vector; the 417th vector has sample count 0.
REQ-026 frame_start_i asserted at beat 7 of the second buffered vector -> out_valid_o=0 next cycle and busy_o=0; a simultaneous data_valid_i instead starts a fresh beat 0 as sample 0.
REQ-027 reset_ni pulsed low during beat 5 -> all outputs return to reset values asynchronously, and the stream restarts cleanly afterwards.
